// File: rtl/buffer_ctrl_pkg.sv
// Shared definitions for the circular-buffer read/write controllers.
// Holds the controller state encoding, default geometry and pointer constants.
// No logic; imported by write_controller and, later, the read-side controller.
package buffer_ctrl_pkg;

  // Two-bit controller state; all four encodings are used.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD    = 2'b01,
    COMMIT  = 2'b10,
    RELEASE = 2'b11
  } state_t;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_ADDR_W = 3;
  localparam int DEFAULT_OVF_W  = 4;

  // Pointer step shared by both sides of the buffer.
  localparam int PTR_STEP = 1;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MOD up-counter used for the buffer write (and later read) pointer.
// Ports: clk, rst (async active-high), inc (advance by one), q (count).
// q updates on the edge after inc=1 and wraps MOD-1 -> 0.
module wrap_counter #(
  parameter int WIDTH = 3,
  parameter int MOD   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == LAST) ? '0 : q + WIDTH'(buffer_ctrl_pkg::PTR_STEP);
    end
  end

endmodule

// File: rtl/write_controller.sv
// Write-side control FSM for the circular buffer: one write per w_en request.
// Ports: clk, rst, w_en, full in; ready, w_mem, w_cnt, w_addr out;
//        ovf_cnt out only when WRITE_CTRL_OVF_CNT_EN is defined.
// A request is taken from IDLE (LOAD strobes, COMMIT bumps the pointer);
// a held w_en parks in RELEASE. All outputs are registered.
module write_controller
  import buffer_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int OVF_W  = DEFAULT_OVF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic              full,
  output logic              ready,
  output logic              w_mem,
  output logic              w_cnt,
  output logic [ADDR_W-1:0] w_addr
`ifdef WRITE_CTRL_OVF_CNT_EN
  ,
  output logic [OVF_W-1:0]  ovf_cnt
`endif
);

  // Elaboration-time sanity check of the geometry.
  generate
    if (DEPTH < 2 || DEPTH != (1 << ADDR_W) || OVF_W < 1) begin : g_bad_cfg
      $error("write_controller: DEPTH must be 2**ADDR_W (>=2) and OVF_W >= 1");
    end
  endgenerate

  state_t state;

  // Strobes are computed from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b0;
      w_mem <= 1'b0;
      w_cnt <= 1'b0;
    end else begin
      ready <= 1'b0;
      w_mem <= 1'b0;
      w_cnt <= 1'b0;
      case (state)
        IDLE: begin
          if (w_en && !full) begin
            state <= LOAD;
            ready <= 1'b1;
            w_mem <= 1'b1;
          end
        end
        LOAD: begin
          state <= COMMIT;
          w_cnt <= 1'b1;
        end
        COMMIT: begin
          state <= w_en ? RELEASE : IDLE;
        end
        RELEASE: begin
          if (!w_en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // w_cnt is high exactly during COMMIT, so the pointer moves at its end.
  wrap_counter #(
    .WIDTH (ADDR_W),
    .MOD   (DEPTH)
  ) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (w_cnt),
    .q   (w_addr)
  );

`ifdef WRITE_CTRL_OVF_CNT_EN
  // One count per refused request: counted stays set until w_en drops.
  logic counted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
      counted <= 1'b0;
    end else if (!w_en) begin
      counted <= 1'b0;
    end else if (state == IDLE && full && !counted) begin
      counted <= 1'b1;
      if (ovf_cnt != {OVF_W{1'b1}}) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_write_controller.sv
module tb_write_controller;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int OVF_W  = 2;

  logic              clk;
  logic              rst;
  logic              w_en;
  logic              full;
  logic              ready;
  logic              w_mem;
  logic              w_cnt;
  logic [ADDR_W-1:0] w_addr;
`ifdef WRITE_CTRL_OVF_CNT_EN
  logic [OVF_W-1:0]  ovf_cnt;
`endif

  write_controller #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .OVF_W  (OVF_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .w_en   (w_en),
    .full   (full),
    .ready  (ready),
    .w_mem  (w_mem),
    .w_cnt  (w_cnt),
    .w_addr (w_addr)
`ifdef WRITE_CTRL_OVF_CNT_EN
    ,
    .ovf_cnt(ovf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mem_pulses = 0;
  int cnt_pulses = 0;
  int exp_addr = 0;
  int q_mem [$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single one-cycle request; returns in IDLE with the pointer advanced.
  task automatic do_write();
    q_mem.push_back(exp_addr);
    w_en = 1'b1;
    tick();
    w_en = 1'b0;
    tick();
    tick();
    exp_addr = (exp_addr + 1) % DEPTH;
  endtask

  // Scoreboard monitor: every write strobe must match the next expected address.
  always @(negedge clk) begin
    if (!rst) begin
      if (w_cnt) cnt_pulses++;
      if (w_mem) begin
        mem_pulses++;
        chk("ready_with_wmem", int'(ready), 1);
        if (q_mem.size() == 0) begin
          chk("unexpected_wmem", 1, 0);
        end else begin
          chk("wmem_addr", int'(w_addr), q_mem.pop_front());
        end
      end
    end
  end

  initial begin : stim
    int m0;
    int c0;
    rst  = 1'b1;
    w_en = 1'b0;
    full = 1'b0;
    tick();
    chk("rst_ready", int'(ready), 0);
    chk("rst_wmem", int'(w_mem), 0);
    chk("rst_wcnt", int'(w_cnt), 0);
    chk("rst_waddr", int'(w_addr), 0);
`ifdef WRITE_CTRL_OVF_CNT_EN
    chk("rst_ovf", int'(ovf_cnt), 0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // Single write with cycle-exact strobe checks.
    q_mem.push_back(0);
    w_en = 1'b1;
    tick();
    w_en = 1'b0;
    chk("single_load_ready", int'(ready), 1);
    chk("single_load_wmem", int'(w_mem), 1);
    chk("single_load_wcnt", int'(w_cnt), 0);
    chk("single_load_addr", int'(w_addr), 0);
    tick();
    chk("single_commit_wcnt", int'(w_cnt), 1);
    chk("single_commit_ready", int'(ready), 0);
    chk("single_commit_addr", int'(w_addr), 0);
    tick();
    chk("single_after_wcnt", int'(w_cnt), 0);
    chk("single_after_addr", int'(w_addr), 1);
    exp_addr = 1;

    // Held w_en: one write only, then parked until w_en drops.
    m0 = mem_pulses;
    c0 = cnt_pulses;
    q_mem.push_back(exp_addr);
    w_en = 1'b1;
    repeat (10) tick();
    chk("held_mem_pulses", mem_pulses - m0, 1);
    chk("held_cnt_pulses", cnt_pulses - c0, 1);
    chk("held_wmem_low", int'(w_mem), 0);
    w_en = 1'b0;
    tick();
    tick();
    exp_addr = (exp_addr + 1) % DEPTH;
    chk("held_addr", int'(w_addr), exp_addr);
    do_write();
    chk("rearm_addr", int'(w_addr), exp_addr);

    // Refusal while full, then acceptance once full drops.
    m0 = mem_pulses;
    c0 = cnt_pulses;
    full = 1'b1;
    w_en = 1'b1;
    repeat (5) tick();
    chk("full_mem_pulses", mem_pulses - m0, 0);
    chk("full_cnt_pulses", cnt_pulses - c0, 0);
    chk("full_addr_hold", int'(w_addr), exp_addr);
`ifdef WRITE_CTRL_OVF_CNT_EN
    chk("full_ovf_once", int'(ovf_cnt), 1);
`endif
    q_mem.push_back(exp_addr);
    full = 1'b0;
    tick();
    chk("full_release_wmem", int'(w_mem), 1);
    w_en = 1'b0;
    tick();
    tick();
    exp_addr = (exp_addr + 1) % DEPTH;
    chk("full_after_addr", int'(w_addr), exp_addr);

    // Wrap: reset pointer, then nine writes land on 0..7,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_addr = 0;
    chk("wrap_start_addr", int'(w_addr), 0);
    for (int i = 0; i < 9; i++) do_write();
    chk("wrap_end_addr", int'(w_addr), 1);

    // Reset in the middle of a write at address 3.
    do_write();
    do_write();
    chk("mid_pre_addr", int'(w_addr), 3);
    c0 = cnt_pulses;
    w_en = 1'b1;
    tick();
    chk("mid_load_wmem", int'(w_mem), 1);
    chk("mid_load_addr", int'(w_addr), 3);
    rst = 1'b1;
    q_mem.push_back(3); // strobe seen at LOAD before the negedge sample is skipped
    void'(q_mem.pop_back());
    #1;
    chk("mid_rst_ready", int'(ready), 0);
    chk("mid_rst_wmem", int'(w_mem), 0);
    chk("mid_rst_wcnt", int'(w_cnt), 0);
    chk("mid_rst_addr", int'(w_addr), 0);
    w_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("mid_no_wcnt", cnt_pulses - c0, 0);
    chk("mid_addr_after", int'(w_addr), 0);
    exp_addr = 0;

`ifdef WRITE_CTRL_OVF_CNT_EN
    // Saturation of the refused-request counter.
    chk("sat_start", int'(ovf_cnt), 0);
    for (int i = 1; i <= 5; i++) begin
      full = 1'b1;
      w_en = 1'b1;
      tick();
      tick();
      w_en = 1'b0;
      tick();
      chk("sat_ovf", int'(ovf_cnt), (i < 3) ? i : 3);
    end
    full = 1'b0;
    tick();
`endif

    do_write();
    chk("final_addr", int'(w_addr), exp_addr);
    chk("scoreboard_empty", q_mem.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
